// File: rtl/scan_bist_driver.sv
// PRPG/MISR scan BIST driver for a multi-chain scan-inserted core.
// Optional X-masking of scan-out chains: SCAN_BIST_DRIVER_XMASK_EN.
`timescale 1ns/1ps

module scan_bist_driver #(
  parameter int NUM_CHAINS   = 7,
  parameter int CHAIN_LEN    = 32,
  parameter int NUM_PATTERNS = 64
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           seed,
  input  logic [15:0]           golden,
  output logic                  scan_en,
  output logic                  test_en,
  output logic [NUM_CHAINS-1:0] si,
  input  logic [NUM_CHAINS-1:0] so,
`ifdef SCAN_BIST_DRIVER_XMASK_EN
  input  logic [NUM_CHAINS-1:0] so_mask,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           signature
);

  localparam int SW = $clog2(CHAIN_LEN);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [SW-1:0] SLAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PLAST = PW'(NUM_PATTERNS);
  localparam logic [15:0] SEED_ALT = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     misr_q, misr_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic            scan_en_d, test_en_d;
  logic            busy_d, done_d, pass_d;
  logic [15:0]     sig_d;

  logic [NUM_CHAINS-1:0] so_eff;
  logic [15:0]           so_ext;
  logic [15:0]           lfsr_step;
  logic [15:0]           misr_step;

`ifdef SCAN_BIST_DRIVER_XMASK_EN
  assign so_eff = so & ~so_mask;
`else
  assign so_eff = so;
`endif

  assign so_ext = 16'(so_eff);
  assign si     = lfsr_q[NUM_CHAINS-1:0];

  assign lfsr_step = {lfsr_q[14:0],
    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign misr_step = {misr_q[14:0],
    misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]}
    ^ so_ext;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      lfsr_q    <= '0;
      misr_q    <= '0;
      shift_q   <= '0;
      pat_q     <= '0;
      scan_en   <= 1'b0;
      test_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      shift_q   <= shift_d;
      pat_q     <= pat_d;
      scan_en   <= scan_en_d;
      test_en   <= test_en_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      signature <= sig_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    scan_en_d = scan_en;
    test_en_d = test_en;
    busy_d    = busy;
    done_d    = 1'b0;
    pass_d    = pass;
    sig_d     = signature;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          lfsr_d    = (seed == 16'h0000) ? SEED_ALT : seed;
          misr_d    = '0;
          shift_d   = '0;
          pat_d     = '0;
          scan_en_d = 1'b1;
          test_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          scan_en_d = 1'b0;
          test_en_d = 1'b0;
          busy_d    = 1'b0;
          pass_d    = 1'b0;
        end else begin
          lfsr_d  = lfsr_step;
          // first window only loads; nothing valid comes back yet
          if (pat_q != '0)
            misr_d = misr_step;
          shift_d = shift_q + 1'b1;
          if (shift_q == SLAST) begin
            shift_d   = '0;
            scan_en_d = 1'b0;
            if (pat_q < PLAST) begin
              state_d = CAPTURE;
            end else begin
              state_d   = DONE;
              test_en_d = 1'b0;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              sig_d     = misr_step;
              pass_d    = (misr_step == golden);
            end
          end
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d   = IDLE;
          scan_en_d = 1'b0;
          test_en_d = 1'b0;
          busy_d    = 1'b0;
          pass_d    = 1'b0;
        end else begin
          state_d   = SHIFT;
          pat_d     = pat_q + 1'b1;
          scan_en_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_bist_driver.sv
// Directed self-checking bench for scan_bist_driver (7 chains, len 4, 2 patterns).
// Define SCAN_BIST_DRIVER_XMASK_EN to also exercise the so_mask path.
`timescale 1ns/1ps

module tb_scan_bist_driver;

  localparam int NC  = 7;
  localparam int CL  = 4;
  localparam int NP  = 2;
  localparam int RUN = (NP + 1) * CL + NP;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   seed = '0;
  logic [15:0]   golden = '0;
  logic          scan_en, test_en;
  logic [NC-1:0] si, so;
  logic [NC-1:0] so_drv = '0;
  logic [NC-1:0] so_dly = '0;
  logic [NC-1:0] flip = '0;
  logic          loop_en = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   signature;
`ifdef SCAN_BIST_DRIVER_XMASK_EN
  logic [NC-1:0] so_mask = '0;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] sig_keep;

  scan_bist_driver #(
    .NUM_CHAINS(NC),
    .CHAIN_LEN(CL),
    .NUM_PATTERNS(NP)
  ) dut (
    .CK(CK),
    .RST(RST),
    .start(start),
    .abort(abort),
    .seed(seed),
    .golden(golden),
    .scan_en(scan_en),
    .test_en(test_en),
    .si(si),
    .so(so),
`ifdef SCAN_BIST_DRIVER_XMASK_EN
    .so_mask(so_mask),
`endif
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature)
  );

  always #5 CK = ~CK;

  // external loopback: one register between si and so
  always @(posedge CK) so_dly <= si;
  assign so = loop_en ? (so_dly ^ flip) : so_drv;

  function automatic logic [15:0] step(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // reference signature over the busy cycles t = 0..RUN-1
  function automatic logic [15:0] model_sig(
    logic [15:0] sd, logic loop, logic [6:0] cso,
    int flip_t, logic [6:0] flip_m);
    logic [15:0] l, m;
    logic [6:0]  prev, s;
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    m = '0;
    prev = '0;
    for (int t = 0; t < RUN; t++) begin
      s = loop ? prev : cso;
      if (t == flip_t) s = s ^ flip_m;
      if ((t % (CL + 1)) < CL && (t / (CL + 1)) > 0)
        m = step(m) ^ {9'd0, s};
      prev = l[6:0];
      if ((t % (CL + 1)) < CL) l = step(l);
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // leaves the bench in busy cycle 0
  task automatic start_run(logic [15:0] sd, logic [15:0] gd);
    tick();
    seed = sd;
    golden = gd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // bounded wait; returns in the cycle where done is high
  task automatic finish_run();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL run_done: done=%b, required a done pulse", done);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({scan_en, test_en, busy, done, pass} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 00000",
        {scan_en, test_en, busy, done, pass});
    end
    checks++;
    if (signature !== 16'h0000) begin
      errors++;
      $display("FAIL reset_sig: got %h required 0000", signature);
    end
    checks++;
    if (si !== 7'h00) begin
      errors++;
      $display("FAIL reset_si: got %h required 00", si);
    end
    RST = 1'b0;
  endtask

  task automatic test_sequencing();
    logic exp_se;
    start_run(16'h0001, 16'h0000);
    for (int t = 0; t < RUN; t++) begin
      exp_se = ((t % (CL + 1)) < CL);
      checks++;
      if ({scan_en, test_en, busy, done} !== {exp_se, 3'b110}) begin
        errors++;
        $display("FAIL seq_c%0d: se/te/busy/done=%b required %b",
          t, {scan_en, test_en, busy, done}, {exp_se, 3'b110});
      end
      tick();
    end
    checks++;
    if ({scan_en, test_en, busy, done} !== 4'b0001) begin
      errors++;
      $display("FAIL seq_end: se/te/busy/done=%b required 0001",
        {scan_en, test_en, busy, done});
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL seq_after: busy/done=%b required 00", {busy, done});
    end
  endtask

  task automatic test_zero_seed();
    start_run(16'h0000, 16'h0000);
    checks++;
    if (si !== 7'h61) begin
      errors++;
      $display("FAIL zseed_c0: si=%h required 61", si);
    end
    tick();
    checks++;
    if (si !== 7'h43) begin
      errors++;
      $display("FAIL zseed_c1: si=%h required 43", si);
    end
    finish_run();
  endtask

  task automatic test_baseline();
    loop_en = 1'b0;
    so_drv = '0;
    start_run(16'h5A5A, 16'h0000);
    finish_run();
    checks++;
    if ({signature, pass} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL base_g0: sig=%h pass=%b required 0000 1",
        signature, pass);
    end
    start_run(16'h5A5A, 16'h0001);
    finish_run();
    checks++;
    if ({signature, pass} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL base_g1: sig=%h pass=%b required 0000 0",
        signature, pass);
    end
  endtask

  task automatic test_loopback();
    logic [15:0] exp_ok, exp_bad;
    exp_ok  = model_sig(16'h1234, 1'b1, 7'h00, -1, 7'h00);
    exp_bad = model_sig(16'h1234, 1'b1, 7'h00, 11, 7'h08);
    loop_en = 1'b1;
    start_run(16'h1234, exp_ok);
    finish_run();
    checks++;
    if ({signature, pass} !== {exp_ok, 1'b1}) begin
      errors++;
      $display("FAIL loop_ok: sig=%h pass=%b required %h 1",
        signature, pass, exp_ok);
    end
    start_run(16'h1234, exp_ok);
    for (int t = 0; t < RUN; t++) begin
      flip = (t == 11) ? 7'h08 : 7'h00;
      tick();
    end
    flip = '0;
    checks++;
    if ({done, signature, pass} !== {1'b1, exp_bad, 1'b0}) begin
      errors++;
      $display("FAIL loop_flip: done=%b sig=%h pass=%b required 1 %h 0",
        done, signature, pass, exp_bad);
    end
    sig_keep = exp_bad;
    loop_en = 1'b0;
  endtask

  task automatic test_abort();
    int  nbusy;
    bit  seen;
    so_drv = '0;
    start_run(16'h0001, 16'h0000);
    for (int t = 0; t < 6; t++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({scan_en, test_en, busy, done, pass} !== 5'b0) begin
      errors++;
      $display("FAIL abort_ctl: se/te/busy/done/pass=%b required 00000",
        {scan_en, test_en, busy, done, pass});
    end
    checks++;
    if (signature !== sig_keep) begin
      errors++;
      $display("FAIL abort_sig: sig=%h required %h", signature, sig_keep);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: activity=%b required 0", seen);
    end
    start_run(16'h0001, 16'h0000);
    nbusy = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++;
    if (seen !== 1'b1 || nbusy != RUN) begin
      errors++;
      $display("FAIL abort_rerun: done=%b busy_cycles=%0d required 1 %0d",
        seen, nbusy, RUN);
    end
  endtask

  task automatic test_rst_mid();
    bit seen;
    start_run(16'h0001, 16'h0000);
    tick();
    tick();
    tick();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({scan_en, test_en, busy, done, pass, signature, si} !== '0) begin
      errors++;
      $display("FAIL rst_mid: se=%b te=%b busy=%b done=%b pass=%b sig=%h si=%h required all 0",
        scan_en, test_en, busy, done, pass, signature, si);
    end
    tick();
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: activity=%b required 0", seen);
    end
  endtask

`ifdef SCAN_BIST_DRIVER_XMASK_EN
  task automatic test_xmask();
    logic [15:0] exp;
    exp = model_sig(16'h00F0, 1'b0, 7'h7F, -1, 7'h00);
    loop_en = 1'b0;
    so_drv = 7'h7F;
    so_mask = 7'h7F;
    start_run(16'h00F0, 16'h0000);
    finish_run();
    checks++;
    if (signature !== 16'h0000) begin
      errors++;
      $display("FAIL xmask_all: sig=%h required 0000", signature);
    end
    so_mask = 7'h00;
    start_run(16'h00F0, 16'h0000);
    finish_run();
    checks++;
    if (signature !== exp || signature === 16'h0000) begin
      errors++;
      $display("FAIL xmask_none: sig=%h required %h (nonzero)",
        signature, exp);
    end
    so_drv = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequencing();
    test_zero_seed();
    test_baseline();
    test_loopback();
    test_abort();
    test_rst_mid();
`ifdef SCAN_BIST_DRIVER_XMASK_EN
    test_xmask();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
